// File: rtl/load_store_unit_pkg.sv
// Shared types and decode helpers for the load/store unit: funct3 codes,
// access sizes, FSM states and the byte-mask / legality functions.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_RD0,
        ST_REQ1,
        ST_RD1,
        ST_RESP
    } state_e;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] mask;
        case (size_e'(size))
            SZ_B:    mask = 4'b0001;
            SZ_H:    mask = 4'b0011;
            SZ_W:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) begin
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end else begin
            ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals of the load/store unit.
// The master modport is the unit's own view; slave is the surrounding core/memory.
interface load_store_unit_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;

    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    logic          mem_req;
    logic          mem_gnt;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane alignment: wide byte enables, per-beat write data, and
// load extraction with sign/zero extension from the two captured read words.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rd0,
    input  logic [31:0] rd1,
    output logic [7:0]  be8,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] load_data
);

    logic [63:0] wide_wdata;
    logic [31:0] shifted;
    logic        sign_ext;

    // Shifting a 64-bit window lets the upper half carry the spill-over beat.
    always_comb begin
        be8        = {4'b0000, size_mask(funct3[1:0])} << off;
        wide_wdata = {32'h0, wdata} << {off, 3'b000};
        wdata0     = wide_wdata[31:0];
        wdata1     = wide_wdata[63:32];
        shifted    = 32'({rd1, rd0} >> {off, 3'b000});
        sign_ext   = !funct3[2];
        case (size_e'(funct3[1:0]))
            SZ_B:    load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            SZ_H:    load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts one load/store, issues one or two word beats,
// and returns extended load data with a single-cycle response pulse.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1,
    parameter int AW       = 32
) (
    input  logic               clk,
    input  logic               srst_n,
    load_store_unit_if.master  bus
);

    state_e        state;
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [1:0]    off_q;
    logic [AW-1:0] base_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rd0_q;

    logic          req_ready_q;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [31:0]   rsp_rdata_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [3:0]    mem_be_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   mem_wdata_q;

    logic          idle;
    logic [2:0]    cur_funct3;
    logic [1:0]    cur_off;
    logic [31:0]   cur_wdata;
    logic [31:0]   rd0_in;
    logic [31:0]   rd1_in;
    logic [7:0]    be8;
    logic [31:0]   wdata0;
    logic [31:0]   wdata1;
    logic [31:0]   load_data;
    logic          crosses;
    logic          legal;
    logic [AW-1:0] req_base;

    // In IDLE the aligner sees the live request so beat0 can launch on accept;
    // afterwards it works from the latched copy.
    assign idle       = (state == ST_IDLE);
    assign cur_funct3 = idle ? bus.req_funct3    : funct3_q;
    assign cur_off    = idle ? bus.req_addr[1:0] : off_q;
    assign cur_wdata  = idle ? bus.req_wdata     : wdata_q;
    assign rd0_in     = (state == ST_RD0) ? bus.mem_rdata : rd0_q;
    assign rd1_in     = (state == ST_RD1) ? bus.mem_rdata : 32'h0;
    assign crosses    = |be8[7:4];
    assign legal      = funct3_legal(bus.req_we, bus.req_funct3);
    assign req_base   = {bus.req_addr[AW-1:2], 2'b00};

    load_store_unit_align u_align (
        .funct3    (cur_funct3),
        .off       (cur_off),
        .wdata     (cur_wdata),
        .rd0       (rd0_in),
        .rd1       (rd1_in),
        .be8       (be8),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .load_data (load_data)
    );

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state       <= ST_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            base_q      <= '0;
            wdata_q     <= 32'h0;
            rd0_q       <= 32'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        we_q        <= bus.req_we;
                        funct3_q    <= bus.req_funct3;
                        off_q       <= bus.req_addr[1:0];
                        base_q      <= req_base;
                        wdata_q     <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        if (!legal || (crosses && !SPLIT_EN)) begin
                            state       <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end else begin
                            state       <= ST_REQ0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.req_we;
                            mem_be_q    <= be8[3:0];
                            mem_addr_q  <= req_base;
                            mem_wdata_q <= bus.req_we ? wdata0 : 32'h0;
                        end
                    end
                end
                ST_REQ0: begin
                    if (bus.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (!we_q) begin
                            state <= ST_RD0;
                        end else if (crosses) begin
                            state       <= ST_REQ1;
                            mem_req_q   <= 1'b1;
                            mem_be_q    <= be8[7:4];
                            mem_addr_q  <= base_q + AW'(4);
                            mem_wdata_q <= wdata1;
                        end else begin
                            state       <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end
                    end
                end
                ST_RD0: begin
                    if (bus.mem_rvalid) begin
                        rd0_q <= bus.mem_rdata;
                        if (crosses) begin
                            state       <= ST_REQ1;
                            mem_req_q   <= 1'b1;
                            mem_be_q    <= be8[7:4];
                            mem_addr_q  <= base_q + AW'(4);
                            mem_wdata_q <= 32'h0;
                        end else begin
                            state       <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= load_data;
                        end
                    end
                end
                ST_REQ1: begin
                    if (bus.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (we_q) begin
                            state       <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end else begin
                            state <= ST_RD1;
                        end
                    end
                end
                ST_RD1: begin
                    if (bus.mem_rvalid) begin
                        state       <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= load_data;
                    end
                end
                ST_RESP: begin
                    state       <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a split-enabled instance served by a
// small memory responder, plus a split-disabled instance for the error path.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic clk = 1'b0;
    logic srst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.AW(32)) b0();
    load_store_unit_if #(.AW(32)) b1();

    load_store_unit #(.SPLIT_EN(1'b1), .AW(32)) dut (
        .clk    (clk),
        .srst_n (srst_n),
        .bus    (b0)
    );

    load_store_unit #(.SPLIT_EN(1'b0), .AW(32)) dut_nosplit (
        .clk    (clk),
        .srst_n (srst_n),
        .bus    (b1)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int c0 = 0;
    int nosplit_req_cycles = 0;

    logic gnt_en = 1'b1;
    logic hold_rv = 1'b0;
    logic force_rv = 1'b0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] beat_addr[$];
    logic [3:0]  beat_be[$];
    logic [31:0] beat_wdata[$];
    logic        beat_we[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: grants while gnt_en, returns read data the cycle after a read grant.
    initial begin
        logic        pend;
        logic [31:0] pend_addr;
        pend = 1'b0;
        pend_addr = 32'h0;
        b0.mem_gnt = 1'b0; b0.mem_rvalid = 1'b0; b0.mem_rdata = 32'h0;
        b1.mem_gnt = 1'b1; b1.mem_rvalid = 1'b0; b1.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            b0.mem_rvalid = (pend && !hold_rv) || force_rv;
            b0.mem_rdata  = force_rv ? 32'hCAFEBABE :
                            (pend && mem.exists(pend_addr)) ? mem[pend_addr] : 32'h0;
            b0.mem_gnt    = b0.mem_req && gnt_en;
            pend          = b0.mem_gnt && !b0.mem_we;
            pend_addr     = b0.mem_addr;
            if (b0.mem_gnt) begin
                beat_addr.push_back(b0.mem_addr);
                beat_be.push_back(b0.mem_be);
                beat_wdata.push_back(b0.mem_wdata);
                beat_we.push_back(b0.mem_we);
            end
            if (b1.mem_req) nosplit_req_cycles++;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic issue_req(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        beat_addr.delete(); beat_be.delete(); beat_wdata.delete(); beat_we.delete();
        @(negedge clk);
        b0.req_valid = 1'b1; b0.req_we = we; b0.req_funct3 = f3;
        b0.req_addr = addr; b0.req_wdata = wdata;
        c0 = cyc;
        @(posedge clk);
        @(negedge clk);
        b0.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic seen, output int lat, output logic [31:0] rdata,
                            output logic err, output int len);
        seen = 1'b0; lat = -1; rdata = 32'h0; err = 1'b0; len = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (b0.rsp_valid === 1'b1) begin
                seen = 1'b1; lat = cyc - c0; rdata = b0.rsp_rdata; err = b0.rsp_err;
            end else begin
                @(negedge clk);
            end
        end
        while (seen && b0.rsp_valid === 1'b1 && len < 4) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic seen, output int lat,
                          output logic [31:0] rdata, output logic err, output int len);
        issue_req(we, f3, addr, wdata);
        wait_rsp(seen, lat, rdata, err, len);
    endtask

    task automatic test_reset();
        srst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (b0.req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b want 1", b0.req_ready); end
        tests_run++; if (b0.mem_req !== 1'b0 || b0.rsp_valid !== 1'b0 || b0.rsp_err !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL reset_ctrl: mem_req=%b rsp_valid=%b rsp_err=%b want 0/0/0", b0.mem_req, b0.rsp_valid, b0.rsp_err); end
        tests_run++; if (b0.rsp_rdata !== 32'h0 || b0.mem_be !== 4'h0 || b0.mem_wdata !== 32'h0) begin
            tests_failed++; $display("[TB] FAIL reset_data: rdata=%h be=%b wdata=%h want zeros", b0.rsp_rdata, b0.mem_be, b0.mem_wdata); end
        srst_n = 1'b1;
    endtask

    task automatic test_store_aligned();
        logic seen, err; int lat, len; logic [31:0] rd;
        do_req(1'b1, F3_SW, 32'h100, 32'hDEADBEEF, seen, lat, rd, err, len);
        tests_run++; if (!seen || lat != 2) begin tests_failed++; $display("[TB] FAIL sw_latency: got %0d want 2", lat); end
        tests_run++; if (len != 1) begin tests_failed++; $display("[TB] FAIL sw_pulse_len: got %0d want 1", len); end
        tests_run++; if (err !== 1'b0 || rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL sw_rsp: err=%b rdata=%h want 0/0", err, rd); end
        tests_run++;
        if (beat_addr.size() != 1) begin tests_failed++; $display("[TB] FAIL sw_beats: got %0d want 1", beat_addr.size()); end
        else if (beat_addr[0] !== 32'h100 || beat_be[0] !== 4'b1111 || beat_wdata[0] !== 32'hDEADBEEF || beat_we[0] !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL sw_beat: addr=%h be=%b wdata=%h we=%b want 100/1111/deadbeef/1", beat_addr[0], beat_be[0], beat_wdata[0], beat_we[0]); end
    endtask

    task automatic test_load_byte();
        logic seen, err; int lat, len; logic [31:0] rd;
        mem[32'h100] = 32'h80112233;
        do_req(1'b0, F3_LB, 32'h103, 32'h0, seen, lat, rd, err, len);
        tests_run++; if (!seen || lat != 3) begin tests_failed++; $display("[TB] FAIL lb_latency: got %0d want 3", lat); end
        tests_run++; if (rd !== 32'hFFFFFF80 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL lb_data: got %h err=%b want ffffff80", rd, err); end
        tests_run++;
        if (beat_addr.size() != 1) begin tests_failed++; $display("[TB] FAIL lb_beats: got %0d want 1", beat_addr.size()); end
        else if (beat_addr[0] !== 32'h100 || beat_be[0] !== 4'b1000 || beat_we[0] !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL lb_beat: addr=%h be=%b we=%b want 100/1000/0", beat_addr[0], beat_be[0], beat_we[0]); end
        do_req(1'b0, F3_LBU, 32'h103, 32'h0, seen, lat, rd, err, len);
        tests_run++; if (!seen || rd !== 32'h00000080) begin tests_failed++; $display("[TB] FAIL lbu_data: got %h want 00000080", rd); end
    endtask

    task automatic test_load_half();
        logic seen, err; int lat, len; logic [31:0] rd;
        do_req(1'b0, F3_LH, 32'h101, 32'h0, seen, lat, rd, err, len);
        tests_run++; if (!seen || rd !== 32'h00001122 || lat != 3) begin tests_failed++; $display("[TB] FAIL lh_off1: got %h lat %0d want 00001122 lat 3", rd, lat); end
        tests_run++;
        if (beat_be.size() != 1) begin tests_failed++; $display("[TB] FAIL lh_off1_beats: got %0d want 1", beat_be.size()); end
        else if (beat_be[0] !== 4'b0110) begin tests_failed++; $display("[TB] FAIL lh_off1_be: got %b want 0110", beat_be[0]); end
        do_req(1'b0, F3_LH, 32'h102, 32'h0, seen, lat, rd, err, len);
        tests_run++; if (!seen || rd !== 32'hFFFF8011) begin tests_failed++; $display("[TB] FAIL lh_sign: got %h want ffff8011", rd); end
        do_req(1'b0, F3_LHU, 32'h102, 32'h0, seen, lat, rd, err, len);
        tests_run++; if (!seen || rd !== 32'h00008011) begin tests_failed++; $display("[TB] FAIL lhu_zero: got %h want 00008011", rd); end
    endtask

    task automatic test_load_split();
        logic seen, err; int lat, len; logic [31:0] rd;
        mem[32'h100] = 32'h44332211;
        mem[32'h104] = 32'h88776655;
        do_req(1'b0, F3_LW, 32'h102, 32'h0, seen, lat, rd, err, len);
        tests_run++; if (!seen || lat != 5) begin tests_failed++; $display("[TB] FAIL lw_split_latency: got %0d want 5", lat); end
        tests_run++; if (rd !== 32'h66554433 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL lw_split_data: got %h want 66554433", rd); end
        tests_run++;
        if (beat_addr.size() != 2) begin tests_failed++; $display("[TB] FAIL lw_split_beats: got %0d want 2", beat_addr.size()); end
        else if (beat_addr[0] !== 32'h100 || beat_be[0] !== 4'b1100 || beat_addr[1] !== 32'h104 || beat_be[1] !== 4'b0011) begin
            tests_failed++; $display("[TB] FAIL lw_split_beat: %h/%b %h/%b want 100/1100 104/0011", beat_addr[0], beat_be[0], beat_addr[1], beat_be[1]); end
    endtask

    task automatic test_store_split();
        logic seen, err; int lat, len; logic [31:0] rd;
        do_req(1'b1, F3_SH, 32'h103, 32'h0000ABCD, seen, lat, rd, err, len);
        tests_run++; if (!seen || lat != 3) begin tests_failed++; $display("[TB] FAIL sh_split_latency: got %0d want 3", lat); end
        tests_run++;
        if (beat_addr.size() != 2) begin tests_failed++; $display("[TB] FAIL sh_split_beats: got %0d want 2", beat_addr.size()); end
        else if (beat_addr[0] !== 32'h100 || beat_be[0] !== 4'b1000 || beat_wdata[0] !== 32'hCD000000 ||
                 beat_addr[1] !== 32'h104 || beat_be[1] !== 4'b0001 || beat_wdata[1] !== 32'h000000AB) begin
            tests_failed++; $display("[TB] FAIL sh_split_beat: %h/%b/%h %h/%b/%h want 100/1000/cd000000 104/0001/000000ab",
                beat_addr[0], beat_be[0], beat_wdata[0], beat_addr[1], beat_be[1], beat_wdata[1]); end
        do_req(1'b1, F3_SH, 32'hFFFFFFFF, 32'h00001234, seen, lat, rd, err, len);
        tests_run++;
        if (beat_addr.size() != 2) begin tests_failed++; $display("[TB] FAIL sh_wrap_beats: got %0d want 2", beat_addr.size()); end
        else if (beat_addr[0] !== 32'hFFFFFFFC || beat_wdata[0] !== 32'h34000000 || beat_addr[1] !== 32'h0 || beat_wdata[1] !== 32'h00000012) begin
            tests_failed++; $display("[TB] FAIL sh_wrap_beat: %h/%h %h/%h want fffffffc/34000000 0/00000012",
                beat_addr[0], beat_wdata[0], beat_addr[1], beat_wdata[1]); end
    endtask

    task automatic test_gnt_stall();
        logic seen, err, stable; int lat, len; logic [31:0] rd;
        gnt_en = 1'b0;
        issue_req(1'b1, F3_SW, 32'h200, 32'h12345678);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (b0.mem_req !== 1'b1 || b0.mem_addr !== 32'h200 || b0.mem_be !== 4'b1111 ||
                b0.mem_wdata !== 32'h12345678 || b0.mem_we !== 1'b1) stable = 1'b0;
            @(negedge clk);
        end
        tests_run++; if (stable !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_hold: beat fields changed, got %b want 1", stable); end
        gnt_en = 1'b1;
        wait_rsp(seen, lat, rd, err, len);
        tests_run++; if (!seen || lat != 7 || beat_addr.size() != 1) begin
            tests_failed++; $display("[TB] FAIL stall_rsp: lat %0d beats %0d want 7/1", lat, beat_addr.size()); end
    endtask

    task automatic test_nosplit();
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_funct3 = F3_LW;
        b1.req_addr = 32'h101; b1.req_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        b1.req_valid = 1'b0;
        tests_run++; if (b1.rsp_valid !== 1'b1 || b1.rsp_err !== 1'b1 || b1.rsp_rdata !== 32'h0) begin
            tests_failed++; $display("[TB] FAIL nosplit_err: valid=%b err=%b rdata=%h want 1/1/0", b1.rsp_valid, b1.rsp_err, b1.rsp_rdata); end
        @(negedge clk);
        tests_run++; if (b1.rsp_valid !== 1'b0 || b1.req_ready !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL nosplit_after: valid=%b ready=%b want 0/1", b1.rsp_valid, b1.req_ready); end
        tests_run++; if (nosplit_req_cycles != 0) begin tests_failed++; $display("[TB] FAIL nosplit_mem_req: got %0d cycles want 0", nosplit_req_cycles); end
    endtask

    task automatic test_reset_mid();
        logic seen, err, any_rsp; int lat, len; logic [31:0] rd;
        hold_rv = 1'b1;
        issue_req(1'b0, F3_LW, 32'h100, 32'h0);
        @(negedge clk);
        srst_n = 1'b0;
        @(negedge clk);
        srst_n = 1'b1;
        hold_rv = 1'b0;
        tests_run++; if (b0.mem_req !== 1'b0 || b0.rsp_valid !== 1'b0 || b0.req_ready !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL midreset_state: mem_req=%b rsp_valid=%b ready=%b want 0/0/1", b0.mem_req, b0.rsp_valid, b0.req_ready); end
        force_rv = 1'b1;
        @(negedge clk);
        force_rv = 1'b0;
        any_rsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (b0.rsp_valid !== 1'b0 || b0.mem_req !== 1'b0) any_rsp = 1'b1;
            @(negedge clk);
        end
        tests_run++; if (any_rsp !== 1'b0) begin tests_failed++; $display("[TB] FAIL stale_rvalid: activity seen %b want 0", any_rsp); end
        do_req(1'b0, 3'b011, 32'h100, 32'h0, seen, lat, rd, err, len);
        tests_run++; if (!seen || lat != 1 || err !== 1'b1 || rd !== 32'h0 || beat_addr.size() != 0) begin
            tests_failed++; $display("[TB] FAIL illegal_load: lat %0d err %b rdata %h beats %0d want 1/1/0/0", lat, err, rd, beat_addr.size()); end
        do_req(1'b1, 3'b100, 32'h100, 32'h0, seen, lat, rd, err, len);
        tests_run++; if (!seen || err !== 1'b1 || beat_addr.size() != 0) begin
            tests_failed++; $display("[TB] FAIL illegal_store: err %b beats %0d want 1/0", err, beat_addr.size()); end
        do_req(1'b0, F3_LBU, 32'h101, 32'h0, seen, lat, rd, err, len);
        tests_run++; if (!seen || rd !== 32'h00000022 || err !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL post_reset_load: got %h err %b want 00000022/0", rd, err); end
    endtask

    initial begin
        b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_funct3 = 3'b000;
        b0.req_addr = 32'h0; b0.req_wdata = 32'h0;
        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_funct3 = 3'b000;
        b1.req_addr = 32'h0; b1.req_wdata = 32'h0;
        test_reset();
        test_store_aligned();
        test_load_byte();
        test_load_half();
        test_load_split();
        test_store_split();
        test_gnt_stall();
        test_nosplit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
